// File: rtl/mdio_pkg.sv
// Shared constants and state encoding for the MDIO responder.
// Frame layout: ST[2] OP[2] PHYAD[5] REGAD[5] TA[2] DATA[16], MSB first.
package mdio_pkg;

  localparam int unsigned OpW   = 2;
  localparam int unsigned PhyW  = 5;
  localparam int unsigned RegW  = 5;
  localparam int unsigned TaW   = 2;
  localparam int unsigned DataW = 16;
  localparam int unsigned HdrW  = OpW + PhyW + RegW;

  localparam logic [1:0] ST_PAT = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_WR  = 2'b01;

  // Last bit index of each counted field (bit counter is 5 bits wide).
  localparam logic [4:0] HdrLast  = 5'(HdrW - 1);
  localparam logic [4:0] TaLast   = 5'(TaW - 1);
  localparam logic [4:0] DataLast = 5'(DataW - 1);

  localparam logic [5:0] PreambleLen = 6'd32;

  typedef enum logic [4:0] {
    StIdle = 5'b00001,
    StSt1  = 5'b00010,
    StHdr  = 5'b00100,
    StTa   = 5'b01000,
    StData = 5'b10000
  } mdio_state_e;

endpackage

// File: rtl/mdio_responder_if.sv
// Serial management bus between station (master) and responder (slave).
interface mdio_responder_if;
  logic mdc;
  logic mdio_i;
  logic mdio_o;
  logic mdio_oe;

  modport master (
    output mdc,
    output mdio_i,
    input  mdio_o,
    input  mdio_oe
  );

  modport slave (
    input  mdc,
    input  mdio_i,
    output mdio_o,
    output mdio_oe
  );
endinterface

// File: rtl/mdio_sync.sv
// Two-flop synchronizer with rising-edge detect on the synchronized level.
module mdio_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  // [1:0] synchronizer stages, [2] previous synchronized level for edge detect
  logic [2:0] sync_q, sync_d;

  // Shift the async input through the chain.
  always_comb begin
    sync_d = {sync_q[1:0], d_i};
  end

  // Synchronizer flops, cleared by synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o    = sync_q[1];
  assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/mdio_responder.sv
// MDIO (clause 22) responder with a 32x16 register file.
// Optional build macro MDIO_RESP_PREAMBLE_EN: require 32 consecutive ones in IDLE
// before a start bit is accepted.
module mdio_responder
  import mdio_pkg::*;
#(
  parameter logic [PhyW-1:0]  PHY_ADDR = 5'd0,
  parameter logic [DataW-1:0] RST_VAL  = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  mdio_responder_if.slave  mdio,
  output logic             wr_strobe,
  output logic [RegW-1:0]  wr_addr,
  output logic [DataW-1:0] wr_data,
  output logic             frame_done,
  output logic             frame_err
);

  logic mdc_rise;
  logic mdc_level_unused;
  logic mdio_s;
  logic mdio_rise_unused;

  mdio_sync u_mdc_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (mdio.mdc),
    .q_o    (mdc_level_unused),
    .rise_o (mdc_rise)
  );

  // Same depth as the mdc path so the data bit lines up with its clock edge.
  mdio_sync u_mdio_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (mdio.mdio_i),
    .q_o    (mdio_s),
    .rise_o (mdio_rise_unused)
  );

  mdio_state_e       state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [HdrW-2:0]   hdr_q, hdr_d;
  logic [RegW-1:0]   regad_q, regad_d;
  logic              is_rd_q, is_rd_d;
  logic              match_q, match_d;
  logic [DataW-1:0]  shift_q, shift_d;
  logic              mdio_o_q, mdio_o_d;
  logic              mdio_oe_q, mdio_oe_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [RegW-1:0]   wr_addr_q, wr_addr_d;
  logic [DataW-1:0]  wr_data_q, wr_data_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_err_q, frame_err_d;
`ifdef MDIO_RESP_PREAMBLE_EN
  logic [5:0]        pre_cnt_q, pre_cnt_d;
`endif

  logic [DataW-1:0]  regs_q [2**RegW];
  logic              reg_we;

  logic [HdrW-1:0]   hdr_full;
  logic [OpW-1:0]    hdr_op;
  logic [PhyW-1:0]   hdr_phy;
  logic [RegW-1:0]   hdr_reg;
  logic [DataW-1:0]  shift_in;
  logic [DataW-1:0]  rd_val;

  assign hdr_full = {hdr_q, mdio_s};
  assign hdr_op   = hdr_full[HdrW-1 -: OpW];
  assign hdr_phy  = hdr_full[RegW +: PhyW];
  assign hdr_reg  = hdr_full[RegW-1:0];
  assign shift_in = {shift_q[DataW-2:0], mdio_s};
  assign rd_val   = regs_q[regad_q];

  // Frame FSM: next state, bit counter, shift registers and output pulses.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hdr_d        = hdr_q;
    regad_d      = regad_q;
    is_rd_d      = is_rd_q;
    match_d      = match_q;
    shift_d      = shift_q;
    mdio_o_d     = mdio_o_q;
    mdio_oe_d    = mdio_oe_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_strobe_d  = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    reg_we       = 1'b0;
`ifdef MDIO_RESP_PREAMBLE_EN
    pre_cnt_d    = pre_cnt_q;
`endif

    if (mdc_rise) begin
      unique case (state_q)
        StIdle: begin
`ifdef MDIO_RESP_PREAMBLE_EN
          if (mdio_s == ST_PAT[1]) begin
            if (pre_cnt_q == PreambleLen) state_d = StSt1;
            pre_cnt_d = '0;
          end else if (pre_cnt_q != PreambleLen) begin
            pre_cnt_d = pre_cnt_q + 6'd1;
          end
`else
          if (mdio_s == ST_PAT[1]) state_d = StSt1;
`endif
        end
        StSt1: begin
          if (mdio_s == ST_PAT[0]) state_d = StHdr;
        end
        StHdr: begin
          hdr_d = hdr_full[HdrW-2:0];
          if (cnt_q == HdrLast) begin
            if (hdr_op == OP_RD || hdr_op == OP_WR) begin
              state_d = StTa;
              regad_d = hdr_reg;
              is_rd_d = (hdr_op == OP_RD);
              match_d = (hdr_phy == PHY_ADDR);
            end else begin
              state_d     = StIdle;
              frame_err_d = 1'b1;
            end
          end
        end
        StTa: begin
          if (match_q && is_rd_q) begin
            if (cnt_q == '0) begin
              // Take the bus and hold the turnaround zero; capture read data.
              shift_d   = rd_val;
              mdio_oe_d = 1'b1;
              mdio_o_d  = 1'b0;
            end else begin
              mdio_o_d = shift_q[DataW-1];
              shift_d  = shift_in;
            end
          end
          if (cnt_q == TaLast) state_d = StData;
        end
        StData: begin
          shift_d = shift_in;
          if (match_q && is_rd_q) mdio_o_d = shift_q[DataW-1];
          if (cnt_q == DataLast) begin
            state_d   = StIdle;
            mdio_oe_d = 1'b0;
            mdio_o_d  = 1'b0;
            if (match_q) begin
              frame_done_d = 1'b1;
              if (!is_rd_q) begin
                reg_we      = 1'b1;
                wr_strobe_d = 1'b1;
                wr_addr_d   = regad_q;
                wr_data_d   = shift_in;
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase

      if (state_d == state_q && (state_q == StHdr || state_q == StTa || state_q == StData)) begin
        cnt_d = cnt_q + 5'd1;
      end else begin
        cnt_d = '0;
      end
    end
  end

  // Frame state and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      hdr_q        <= '0;
      regad_q      <= '0;
      is_rd_q      <= 1'b0;
      match_q      <= 1'b0;
      shift_q      <= '0;
      mdio_o_q     <= 1'b0;
      mdio_oe_q    <= 1'b0;
      wr_strobe_q  <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef MDIO_RESP_PREAMBLE_EN
      pre_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hdr_q        <= hdr_d;
      regad_q      <= regad_d;
      is_rd_q      <= is_rd_d;
      match_q      <= match_d;
      shift_q      <= shift_d;
      mdio_o_q     <= mdio_o_d;
      mdio_oe_q    <= mdio_oe_d;
      wr_strobe_q  <= wr_strobe_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
`ifdef MDIO_RESP_PREAMBLE_EN
      pre_cnt_q    <= pre_cnt_d;
`endif
    end
  end

  // Register file; written only when a matched write frame commits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2**RegW; i++) regs_q[i] <= RST_VAL;
    end else if (reg_we) begin
      regs_q[regad_q] <= shift_in;
    end
  end

  assign mdio.mdio_o  = mdio_o_q;
  assign mdio.mdio_oe = mdio_oe_q;
  assign wr_strobe    = wr_strobe_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign frame_done   = frame_done_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_mdio_responder.sv
// Scoreboard bench for mdio_responder: directed frames plus random traffic
// checked against a register-array model of the responder.
module tb_mdio_responder;
  import mdio_pkg::*;

  localparam logic [4:0]  PhyAddr = 5'd0;
  localparam logic [15:0] RstVal  = 16'hC3A5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_strobe, frame_done, frame_err;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;

  mdio_responder_if mif ();

  mdio_responder #(
    .PHY_ADDR (PhyAddr),
    .RST_VAL  (RstVal)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mdio       (mif),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [4:0]  addr;
    logic [15:0] data;
  } wr_exp_t;

  wr_exp_t     q_wr[$];
  logic        q_done[$];   // per matched frame: was it a write
  logic        q_err[$];
  logic [15:0] q_rd[$];
  logic [15:0] model [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pulse monitor: pops expectations whenever the DUT strobes.
  wr_exp_t we_pop;
  logic    done_pop;
  logic    err_pop;
  always @(negedge clk) begin
    if (rst) begin
      if (wr_strobe) begin
        if (q_wr.size() == 0) check("wr_strobe_unexpected", 1, 0);
        else begin
          we_pop = q_wr.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(we_pop.addr));
          check("wr_data", 32'(wr_data), 32'(we_pop.data));
        end
      end
      if (frame_done) begin
        if (q_done.size() == 0) check("frame_done_unexpected", 1, 0);
        else begin
          done_pop = q_done.pop_front();
          check("done_with_strobe", 32'(wr_strobe), 32'(done_pop));
        end
      end
      if (frame_err) begin
        if (q_err.size() == 0) check("frame_err_unexpected", 1, 0);
        else begin
          err_pop = q_err.pop_front();
          check("err_alone", 32'({wr_strobe, frame_done}), 32'(2'b00));
        end
      end
    end
  end

  // Read monitor: station samples mdio on rising mdc; a driven burst ends
  // at the first rise where the responder has released the line.
  logic [16:0] rd_bits = '0;
  int          rd_n = 0;
  logic [15:0] rd_pop;
  always @(posedge mif.mdc) begin
    if (mif.mdio_oe === 1'b1) begin
      rd_bits = {rd_bits[15:0], mif.mdio_o};
      rd_n++;
    end else if (rd_n > 0) begin
      if (q_rd.size() == 0) check("read_unexpected", 1, 0);
      else begin
        rd_pop = q_rd.pop_front();
        check("read_len", 32'(rd_n), 32'd17);
        check("read_data", 32'(rd_bits), 32'({1'b0, rd_pop}));
      end
      rd_n = 0;
    end
  end

  task automatic send_bit(input logic b);
    mif.mdc    = 1'b0;
    mif.mdio_i = b;
    #40;
    mif.mdc    = 1'b1;
    #40;
  endtask

  task automatic send_frame(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra,
                            input logic [1:0] ta, input logic [15:0] dat, input int nbits,
                            input int idle);
    logic [31:0] bits;
    bits = {ST_PAT, op, phy, ra, ta, dat};
    repeat (idle) send_bit(1'b1);
    for (int i = 31; i > 31 - nbits; i--) send_bit(bits[i]);
  endtask

  task automatic do_write(input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] dat);
    if (phy == PhyAddr) begin
      q_wr.push_back({ra, dat});
      q_done.push_back(1'b1);
      model[ra] = dat;
    end
    send_frame(OP_WR, phy, ra, 2'b10, dat, 32, 34);
  endtask

  task automatic do_read(input logic [4:0] phy, input logic [4:0] ra);
    if (phy == PhyAddr) begin
      q_rd.push_back(model[ra]);
      q_done.push_back(1'b0);
    end
    send_frame(OP_RD, phy, ra, 2'b11, 16'hFFFF, 32, 34);
  endtask

  task automatic do_bad(input logic [1:0] op, input logic [4:0] ra);
    q_err.push_back(1'b1);
    send_frame(op, PhyAddr, ra, 2'b11, 16'hFFFF, 14, 34);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [4:0]  ra;
  logic [4:0]  phy;
  logic [15:0] dat;
  int unsigned kind;

  initial begin
    for (int i = 0; i < 32; i++) model[i] = RstVal;
    mif.mdc    = 1'b0;
    mif.mdio_i = 1'b1;
    rst        = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_mdio_oe", 32'(mif.mdio_oe), 0);
    check("rst_mdio_o", 32'(mif.mdio_o), 0);
    check("rst_wr_strobe", 32'(wr_strobe), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Basic write then read-back of the same register.
    do_write(PhyAddr, 5'd3, 16'hABCD);
    do_read(PhyAddr, 5'd3);

    // Other PHY addresses are ignored, then a matched frame still decodes.
    do_read(5'd7, 5'd3);
    do_write(5'd9, 5'd3, 16'hDEAD);
    do_read(PhyAddr, 5'd3);

    // Illegal opcodes.
    do_bad(2'b00, 5'd3);
    do_bad(2'b11, 5'd6);
    do_read(PhyAddr, 5'd3);

    // Address extremes and reset-value reads.
    do_write(PhyAddr, 5'd31, 16'hFFFF);
    do_write(PhyAddr, 5'd0, 16'h0001);
    do_read(PhyAddr, 5'd31);
    do_read(PhyAddr, 5'd0);
    do_read(PhyAddr, 5'd20);
    do_write(PhyAddr, 5'd5, 16'h1111);
    do_read(PhyAddr, 5'd5);

    // Reset in the middle of a write's data phase.
    send_frame(OP_WR, PhyAddr, 5'd5, 2'b10, 16'h5A5A, 24, 34);
    mif.mdc = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
    check("abort_mdio_oe", 32'(mif.mdio_oe), 0);
    repeat (3) @(negedge clk);
    check("abort_wr_strobe", 32'(wr_strobe), 0);
    check("abort_wr_addr", 32'(wr_addr), 0);
    check("abort_wr_data", 32'(wr_data), 0);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = RstVal;
    repeat (3) @(negedge clk);
    do_read(PhyAddr, 5'd5);
    do_read(PhyAddr, 5'd3);
    do_write(PhyAddr, 5'd9, 16'h0F0F);
    do_read(PhyAddr, 5'd9);

    // Random traffic; small address range to get read-after-write hits.
    for (int n = 0; n < 24; n++) begin
      kind = $urandom_range(0, 9);
      ra   = 5'($urandom_range(0, 7));
      dat  = 16'($urandom_range(0, 65535));
      phy  = ($urandom_range(0, 3) == 0) ? (PhyAddr ^ 5'($urandom_range(1, 31))) : PhyAddr;
      if (kind < 4) do_write(phy, ra, dat);
      else if (kind < 9) do_read(phy, ra);
      else do_bad(($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11, ra);
    end

`ifdef MDIO_RESP_PREAMBLE_EN
    // 31 ones is too short a preamble; 32 is enough.
    send_frame(OP_WR, PhyAddr, 5'd12, 2'b10, 16'hABCD, 32, 31);
    q_wr.push_back({5'd12, 16'hABCD});
    q_done.push_back(1'b1);
    model[12] = 16'hABCD;
    send_frame(OP_WR, PhyAddr, 5'd12, 2'b10, 16'hABCD, 32, 32);
    do_read(PhyAddr, 5'd12);
`endif

    repeat (4) send_bit(1'b1);
    repeat (10) @(negedge clk);
    check("pending_writes", 32'(q_wr.size()), 0);
    check("pending_done", 32'(q_done.size()), 0);
    check("pending_err", 32'(q_err.size()), 0);
    check("pending_reads", 32'(q_rd.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
